// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, single-outstanding data-memory
// handshake, load formatting and store lane steering, registered writeback.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip memory and retire with misalign=1, no register write).
module mem_access_stage #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // execute-stage handshake and payload
   input  logic              exValid,
   output logic              exReady,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              regWrite,
   input  logic [2:0]        funct3,
   input  logic [4:0]        rd,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] storeData,
   // data-memory port
   output logic              dmemReq,
   output logic              dmemWe,
   output logic [DATA_W-1:0] dmemAddr,
   output logic [DATA_W-1:0] dmemWdata,
   output logic [3:0]        dmemBe,
   input  logic              dmemAck,
   input  logic [DATA_W-1:0] dmemRdata,
   // writeback
   output logic              wbValid,
   output logic              wbRegWrite,
   output logic [4:0]        wbRd,
   output logic [DATA_W-1:0] wbData,
   // forwarding and status
   output logic [DATA_W-1:0] dataMemAddr,
   output logic              stall,
   output logic              misalign
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned F3_W  = 3;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_e;

   state_e              state_q;
   logic                dmem_req_q;
   logic                dmem_we_q;
   logic [DATA_W-1:0]   dmem_addr_q;
   logic [DATA_W-1:0]   dmem_wdata_q;
   logic [BE_W-1:0]     dmem_be_q;
   logic                wb_valid_q;
   logic                wb_reg_write_q;
   logic [RD_W-1:0]     wb_rd_q;
   logic [DATA_W-1:0]   wb_data_q;
   logic [DATA_W-1:0]   data_mem_addr_q;
   // held instruction fields used while the access is outstanding
   logic [RD_W-1:0]     rd_q;
   logic                reg_write_q;
   logic                is_store_q;
   logic [F3_W-1:0]     funct3_q;

   logic                mem_op_c;
   logic                is_store_c;
   logic                trap_c;
   logic [BE_W-1:0]     st_be_d;
   logic [DATA_W-1:0]   st_wdata_d;
   logic [7:0]          ld_byte_c;
   logic [15:0]         ld_half_c;
   logic [DATA_W-1:0]   ld_data_d;

   assign mem_op_c   = memRead | memWrite;
   // a write wins when both control bits are set
   assign is_store_c = memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_q;
   logic mis_addr_c;

   // Alignment check against the natural width of the incoming access.
   always_comb begin
      mis_addr_c = 1'b0;
      if (is_store_c) begin
         case (funct3)
            3'b000:  mis_addr_c = 1'b0;
            3'b001:  mis_addr_c = aluResult[0];
            default: mis_addr_c = (aluResult[1:0] != 2'b00);
         endcase
      end else begin
         case (funct3[1:0])
            2'b00:   mis_addr_c = 1'b0;
            2'b01:   mis_addr_c = aluResult[0];
            default: mis_addr_c = (aluResult[1:0] != 2'b00);
         endcase
      end
   end

   assign trap_c   = mem_op_c & mis_addr_c;
   assign misalign = misalign_q;
`else
   assign trap_c   = 1'b0;
   assign misalign = 1'b0;
`endif

   // Store lane steering: byte enables and replicated write data.
   always_comb begin
      st_be_d    = {BE_W{1'b1}};
      st_wdata_d = storeData;
      if (is_store_c) begin
         case (funct3)
            3'b000: begin
               st_be_d    = BE_W'(4'b0001 << aluResult[1:0]);
               st_wdata_d = {4{storeData[7:0]}};
            end
            3'b001: begin
               st_be_d    = aluResult[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
               st_wdata_d = {2{storeData[15:0]}};
            end
            default: begin
               st_be_d    = {BE_W{1'b1}};
               st_wdata_d = storeData;
            end
         endcase
      end else begin
         st_wdata_d = '0;
      end
   end

   // Load formatting: pick byte/half lane from the held address, then extend.
   always_comb begin
      ld_byte_c = 8'h00;
      case (data_mem_addr_q[1:0])
         2'd0: ld_byte_c = dmemRdata[7:0];
         2'd1: ld_byte_c = dmemRdata[15:8];
         2'd2: ld_byte_c = dmemRdata[23:16];
         2'd3: ld_byte_c = dmemRdata[31:24];
         default: ld_byte_c = 8'h00;
      endcase
      ld_half_c = data_mem_addr_q[1] ? dmemRdata[31:16] : dmemRdata[15:0];
      case (funct3_q)
         3'b000:  ld_data_d = {{24{ld_byte_c[7]}}, ld_byte_c};
         3'b100:  ld_data_d = {24'h000000, ld_byte_c};
         3'b001:  ld_data_d = {{16{ld_half_c[15]}}, ld_half_c};
         3'b101:  ld_data_d = {16'h0000, ld_half_c};
         default: ld_data_d = dmemRdata;
      endcase
   end

   // Stage FSM with EX/MEM capture, memory request and writeback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= '0;
         dmem_wdata_q    <= '0;
         dmem_be_q       <= '0;
         wb_valid_q      <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_rd_q         <= '0;
         wb_data_q       <= '0;
         data_mem_addr_q <= '0;
         rd_q            <= '0;
         reg_write_q     <= 1'b0;
         is_store_q      <= 1'b0;
         funct3_q        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q      <= 1'b0;
`endif
      end else begin
         wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (exValid) begin
                  data_mem_addr_q <= aluResult;
                  rd_q            <= rd;
                  reg_write_q     <= regWrite;
                  is_store_q      <= is_store_c;
                  funct3_q        <= funct3;
                  if (mem_op_c && !trap_c) begin
                     state_q      <= S_ACCESS;
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= is_store_c;
                     dmem_addr_q  <= {aluResult[DATA_W-1:2], 2'b00};
                     dmem_be_q    <= st_be_d;
                     dmem_wdata_q <= st_wdata_d;
                  end else begin
                     // ALU result or trapped access retires next cycle
                     wb_valid_q     <= 1'b1;
                     wb_data_q      <= aluResult;
                     wb_rd_q        <= rd;
                     wb_reg_write_q <= regWrite & ~trap_c;
`ifdef MEM_MISALIGN_TRAP_EN
                     misalign_q     <= trap_c;
`endif
                  end
               end
            end
            S_ACCESS: begin
               if (dmemAck) begin
                  state_q        <= S_IDLE;
                  dmem_req_q     <= 1'b0;
                  dmem_we_q      <= 1'b0;
                  wb_valid_q     <= 1'b1;
                  wb_rd_q        <= rd_q;
                  wb_reg_write_q <= reg_write_q & ~is_store_q;
                  wb_data_q      <= is_store_q ? data_mem_addr_q : ld_data_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign exReady     = (state_q == S_IDLE);
   assign stall       = ~exReady;
   assign dmemReq     = dmem_req_q;
   assign dmemWe      = dmem_we_q;
   assign dmemAddr    = dmem_addr_q;
   assign dmemWdata   = dmem_wdata_q;
   assign dmemBe      = dmem_be_q;
   assign wbValid     = wb_valid_q;
   assign wbRegWrite  = wb_reg_write_q;
   assign wbRd        = wb_rd_q;
   assign wbData      = wb_data_q;
   assign dataMemAddr = data_mem_addr_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock; single clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 exValid  in  1  execute stage presents a valid instruction.
REQ-005 exReady  out  1  stage can accept; transfer when exValid&&exReady at posedge.
REQ-006 memRead, memWrite, regWrite  in  1 each  control bits from execute.
REQ-007 funct3  in  3  load/store width/sign; rd  in  5  destination register.
REQ-008 aluResult  in  32  ALU output Y (address or result); storeData  in  32  forwarded rs2 (newRdData2).
REQ-009 dmemReq  out  1; dmemWe  out  1; dmemAddr  out  32 (bits [1:0]=0); dmemWdata  out  32; dmemBe  out  4.
REQ-010 dmemAck  in  1; dmemRdata  in  32  data-memory response.
REQ-011 wbValid  out  1; wbRegWrite  out  1; wbRd  out  5; wbData  out  32  writeback outputs.
REQ-012 dataMemAddr  out  32  registered aluResult of held instruction, forwarding source for execute srcA/srcB=2'b10.
REQ-013 stall  out  1  equals !exReady; misalign  out  1  (tied 0 unless REQ-030).

Function
REQ-014 FSM states: IDLE, ACCESS.
REQ-015 IDLE: exReady=1; on accept, capture all inputs into EX/MEM register; if memRead||memWrite go ACCESS, else stay IDLE.
REQ-016 Non-memory instruction: wbValid=1 cycle after accept, wbData=aluResult, wbRegWrite=regWrite, wbRd=rd; back-to-back accepts each cycle sustain 1 instr/cycle.
REQ-017 ACCESS: exReady=0, dmemReq=1 with dmemAddr/dmemWe/dmemBe/dmemWdata stable until the cycle dmemAck=1 inclusive.
REQ-018 dmemAck sampled high in ACCESS (including first ACCESS cycle) -> next cycle: IDLE, wbValid=1; load: wbData=formatted dmemRdata; store: wbRegWrite=0.
REQ-019 dmemAck while not in ACCESS is ignored.
REQ-020 Memory latency: dmemReq first asserted the cycle after accept; wbValid the cycle after dmemAck; zero-wait memory gives 2 cycles accept-to-wbValid.
REQ-021 Load format (lane = addr[1:0]): 000 LB sign-ext byte; 001 LH sign-ext half (addr[1]); 010 LW; 100 LBU; 101 LHU zero-ext; 011/110/111 treated as LW.
REQ-022 Store: SB dmemBe=4'b0001<<addr[1:0], byte replicated x4; SH dmemBe=addr[1]?1100:0011, half replicated x2; SW and funct3>=011 dmemBe=1111.
REQ-023 Without REQ-030, misaligned low address bits are ignored per width (LH/SH use addr[1], LW/SW ignore addr[1:0]).
REQ-024 wbValid is a single-cycle pulse per instruction; wbData/wbRd hold until next wbValid.
REQ-025 dataMemAddr updates only on accept.
REQ-026 memRead&&memWrite both set: treated as store.

Reset
REQ-027 On rst: state=IDLE; exReady=1; dmemReq, dmemWe, wbValid, wbRegWrite, misalign=0; dmemBe=0; dmemAddr, dmemWdata, wbData, dataMemAddr=0; wbRd=0.
REQ-028 rst during ACCESS deasserts dmemReq at that edge; in-flight instruction discarded, no wbValid; subsequent dmemAck ignored.
REQ-029 rst overrides a simultaneous accept or dmemAck.

Configuration
REQ-030 MEM_MISALIGN_TRAP_EN defined: misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) skips ACCESS, no dmemReq; next cycle wbValid=1, wbRegWrite=0, misalign=1 for one cycle.
REQ-031 MEM_MISALIGN_TRAP_EN undefined: misalign tied 0, REQ-023 applies, no trap logic synthesized.

Verification
REQ-032 ADD result 0x0000_1234, rd=5, three back-to-back -> wbValid 3 consecutive cycles, wbData=0x1234, wbRd=5, stall never high.
REQ-033 LB addr 0x103, dmemRdata=0x80FF_FF7F, ack after 3 wait cycles -> stall 4 cycles, dmemAddr=0x100, wbData=0xFFFF_FF80.
REQ-034 SH addr 0x202, storeData=0xAAAA_BEEF, zero-wait ack -> dmemWe=1, dmemBe=1100, dmemWdata=0xBEEF_BEEF, wbRegWrite=0.
REQ-035 LW issued, rst in second ACCESS cycle, ack next cycle -> dmemReq=0 after rst, no wbValid, exReady=1.
REQ-036 With MEM_MISALIGN_TRAP_EN: LW addr 0x101 -> no dmemReq, misalign=1 and wbValid=1 next cycle, wbRegWrite=0; without: dmemAddr=0x100, normal load.
